// File: rtl/skinny_sbox_seq_ctrl.sv
// skinny_sbox_seq_ctrl: phase scheduler for the iterative masked SKINNY S-box with randomness-starvation abort
module skinny_sbox_seq_ctrl #(
  parameter bit STARVE_ABORT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        rnd_valid,
  output logic        rnd_req,
  output logic        out_valid,
  output logic        busy,
  output logic        err,
  input  logic        err_clr,
  output logic        en2,
  output logic        en3,
  output logic        en4,
  output logic        en5,
  output logic [11:0] ctrl
);
  typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;
  state_t state, state_nx;
  logic [2:0] ph, ph_nx;
  logic run, starve;
  // P0 is the accept cycle itself, so the registered RUN state only ever holds ph 1..6
  always_comb begin
    run = state == RUN;
    in_ready = state == IDLE;
    rnd_req = (in_ready && in_valid) || (run && ph <= 3'd5);
    starve = STARVE_ABORT && rnd_req && !rnd_valid;
    state_nx = starve ? ERR :
               in_ready ? (in_valid ? RUN : IDLE) :
               run ? (ph == 3'd6 ? IDLE : RUN) : IDLE;
    ph_nx = state_nx == RUN ? ph + 3'd1 : 3'd0;
    busy = run;
    out_valid = run && ph == 3'd6;
    en2 = run && ph == 3'd2;
    en3 = run && ph == 3'd3;
    en4 = run && ph == 3'd4;
    en5 = run && ph == 3'd5;
    ctrl = !run ? 12'h000 :
           ph == 3'd1 ? 12'h249 :
           ph == 3'd2 ? 12'h6DB :
           ph == 3'd3 ? 12'h924 :
           ph == 3'd4 ? 12'hB6D :
           ph == 3'd5 ? 12'hFFF :
           ph == 3'd6 ? 12'h492 : 12'h000;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ph <= 3'd0;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      ph <= ph_nx;
      err <= starve || (err && !err_clr);
    end
  end
endmodule

// File: tb/tb_skinny_sbox_seq_ctrl.sv
// tb_skinny_sbox_seq_ctrl: directed-vector bench for the S-box phase controller
module tb_skinny_sbox_seq_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, rnd_valid = 1'b1, err_clr = 1'b0, in_valid1 = 1'b0;
  logic in_ready, rnd_req, out_valid, busy, err, en2, en3, en4, en5;
  logic in_ready1, rnd_req1, out_valid1, busy1, err1, en2_1, en3_1, en4_1, en5_1;
  logic [11:0] ctrl, ctrl1;
  logic [20:0] stat, stat1;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  skinny_sbox_seq_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rnd_valid(rnd_valid), .rnd_req(rnd_req), .out_valid(out_valid), .busy(busy),
    .err(err), .err_clr(err_clr), .en2(en2), .en3(en3), .en4(en4), .en5(en5), .ctrl(ctrl)
  );
  skinny_sbox_seq_ctrl #(.STARVE_ABORT(1'b0)) u_noabort (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .rnd_valid(1'b0), .rnd_req(rnd_req1), .out_valid(out_valid1), .busy(busy1),
    .err(err1), .err_clr(1'b0), .en2(en2_1), .en3(en3_1), .en4(en4_1), .en5(en5_1), .ctrl(ctrl1)
  );
  assign stat = {in_ready, rnd_req, busy, out_valid, err, en2, en3, en4, en5, ctrl};
  assign stat1 = {in_ready1, rnd_req1, busy1, out_valid1, err1, en2_1, en3_1, en4_1, en5_1, ctrl1};
  // fields: in_ready rnd_req busy out_valid err | en2..en5 | ctrl; index 0 = accept cycle, 7 = idle after
  localparam logic [20:0] TBL [8] = '{
    {5'b11000, 4'b0000, 12'h000},
    {5'b01100, 4'b0000, 12'h249},
    {5'b01100, 4'b1000, 12'h6DB},
    {5'b01100, 4'b0100, 12'h924},
    {5'b01100, 4'b0010, 12'hB6D},
    {5'b01100, 4'b0001, 12'hFFF},
    {5'b00110, 4'b0000, 12'h492},
    {5'b10000, 4'b0000, 12'h000}
  };
  localparam logic [20:0] ERRB = 21'h10000;
  localparam logic [20:0] ERRST = {5'b00001, 4'b0000, 12'h000};
  task automatic chk(input string tag, input logic [20:0] got, input logic [20:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%06h exp=%06h", tag, got, exp);
    end
  endtask
  task automatic cyc_chk(input string tag, input logic [20:0] exp);
    @(negedge clk);
    chk(tag, stat, exp);
    @(posedge clk);
    #1;
  endtask
  initial begin
    @(negedge clk);
    chk("reset", stat, TBL[7]);
    chk("reset_noabort", stat1, TBL[7]);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) cyc_chk("idle", TBL[7]);
    for (int k = 0; k < 8; k++) begin
      in_valid = k == 0;
      cyc_chk($sformatf("single_p%0d", k), TBL[k]);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 30; i++) cyc_chk($sformatf("cont_c%0d", i), TBL[i % 7]);
    in_valid = 1'b0;
    for (int i = 30; i < 35; i++) cyc_chk($sformatf("cont_c%0d", i), TBL[i % 7]);
    cyc_chk("cont_idle", TBL[7]);
    for (int k = 0; k < 4; k++) begin
      in_valid = k == 0;
      rnd_valid = k != 3;
      cyc_chk($sformatf("starve_p%0d", k), TBL[k]);
    end
    rnd_valid = 1'b1;
    cyc_chk("starve_err_state", ERRST);
    in_valid = 1'b1;
    cyc_chk("starve_reaccept", TBL[0] | ERRB);
    in_valid = 1'b0;
    for (int k = 1; k < 8; k++) cyc_chk($sformatf("after_err_p%0d", k), TBL[k] | ERRB);
    err_clr = 1'b1;
    cyc_chk("clr_cycle", TBL[7] | ERRB);
    err_clr = 1'b0;
    cyc_chk("clr_done", TBL[7]);
    in_valid = 1'b1;
    rnd_valid = 1'b0;
    cyc_chk("starve_p0", TBL[0]);
    in_valid = 1'b0;
    rnd_valid = 1'b1;
    cyc_chk("starve_p0_err", ERRST);
    cyc_chk("starve_p0_idle", TBL[7] | ERRB);
    in_valid = 1'b1;
    rnd_valid = 1'b0;
    err_clr = 1'b1;
    cyc_chk("set_vs_clr", TBL[0] | ERRB);
    in_valid = 1'b0;
    rnd_valid = 1'b1;
    err_clr = 1'b0;
    cyc_chk("set_wins", ERRST);
    cyc_chk("set_wins_idle", TBL[7] | ERRB);
    for (int k = 0; k < 4; k++) begin
      in_valid = k == 0;
      cyc_chk($sformatf("rst_op_p%0d", k), TBL[k] | ERRB);
    end
    @(negedge clk);
    chk("rst_op_p4", stat, TBL[4] | ERRB);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", stat, TBL[7]);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) cyc_chk($sformatf("rst_after_c%0d", i), TBL[7]);
    for (int k = 0; k < 8; k++) begin
      in_valid1 = k == 0;
      @(negedge clk);
      chk($sformatf("noabort_p%0d", k), stat1, TBL[k]);
      @(posedge clk);
      #1;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/skinny_sbox_seq_ctrl.md
# skinny_sbox_seq_ctrl

Control FSM for the iterative masked SKINNY S-box datapath, `MSKsbox`. It accepts one S-box operation at a time and drives the phase schedule: the output-register enables `en2`–`en5` and the twelve mux selects. It also requests fresh randomness for the two HPC2 AND gadgets on every cycle they are used. The datapath's input delay chains are free-running, so an operation cannot be stalled mid-way. Randomness starvation therefore aborts the operation and raises a sticky error.

## Interface
- `STARVE_ABORT`, default 1. 1 = abort on missing randomness. 0 = ignore `rnd_valid` and never set `err`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: a shared S-box input is present on the datapath `in` bus this cycle.
- `in_ready` out 1: the controller accepts an operation this cycle.
- `rnd_valid` in 1: fresh `rnd` is present for the datapath this cycle.
- `rnd_req` out 1: the datapath consumes `rnd` this cycle.
- `out_valid` out 1: the datapath `out` bus holds the S-box result this cycle.
- `busy` out 1: an operation is in progress.
- `err` out 1: sticky randomness-starvation flag.
- `err_clr` in 1: synchronous clear of `err`.
- `en2`, `en3`, `en4`, `en5` out 1 each: output-register enables.
- `ctrl` out 12: mux selects, packed MSB..LSB as {sel2x2, sel1x2, sel2b2, sel1b2, sel2a2, sel1a2, sel2x1, sel1x1, sel2b1, sel1b1, sel2a1, sel1a1}.

## Operation
- States: IDLE, RUN (3-bit phase counter `ph`, 0..6), ERR.
- Reset:
  - State IDLE, `ph`=0, `err`=0.
  - All outputs 0 except `in_ready`=1.
- IDLE:
  - `in_ready`=1.
  - `in_valid`=1 → RUN, with this cycle as P0.
  - P0 outputs are driven combinationally in the accept cycle, because the AND gadgets register the first operands from the raw input.
- RUN, phase Pk:
  - `busy`=1, `in_ready`=0.
  - `ph` increments every cycle.
  - After P6 → IDLE.
- Control word per phase (hex): P0 000, P1 249, P2 6DB, P3 924, P4 B6D, P5 FFF, P6 492. `ctrl`=000 outside RUN.
- Enables: `en2`=1 only in P2, `en3` only in P3, `en4` only in P4, `en5` only in P5.
- `rnd_req`=1 in P0..P5. It is 0 in P6 and in IDLE/ERR.
- `out_valid`=1 only in P6, for exactly one cycle per completed operation.
- Starvation, `STARVE_ABORT`=1:
  - `rnd_req`=1 and `rnd_valid`=0 in any phase → ERR on the next edge.
  - `err`=1 from that edge.
  - The current cycle's enables and `ctrl` are still driven normally. No `out_valid` is ever issued for that operation.
- ERR:
  - Lasts one cycle: outputs as in IDLE except `in_ready`=0.
  - Then → IDLE.
  - `err` stays 1 until `err_clr`.
- `err_clr` and a new starvation event in the same cycle: set wins, so `err` stays 1.
- `in_valid` while RUN/ERR is ignored. No queueing.
- Reset mid-operation: immediate return to IDLE, all enables and `ctrl` forced to 0, no `out_valid`.

## Timing
- Latency: accept at cycle t, `out_valid` at t+6.
- Throughput: one operation per 7 cycles. The next accept is at t+7 at the earliest.
- Back-to-back overlap is forbidden, because P0 and P6 both use the shared muxes.
- `in_ready`, `rnd_req` and P0 `ctrl` are combinational from state and `in_valid`. All other outputs are decoded from registered state only.
- `err` is registered.
- No combinational path from `rnd_valid` to any output.

## Test plan
- Single operation:
  - Stimulus: `in_valid` pulse at cycle 10, `rnd_valid`=1 throughout.
  - Required: `ctrl` sequence 000, 249, 6DB, 924, B6D, FFF, 492 on cycles 10..16.
  - Required: `en2`..`en5` high on cycles 12..15 respectively.
  - Required: `out_valid` high only on cycle 16, then back to IDLE on cycle 17.
- Continuous `in_valid`=1 for 30 cycles:
  - Required: accepts on cycles 0, 7, 14, 21, 28.
  - Required: `out_valid` on cycles 6, 13, 20, 27.
  - Compare against the golden SKINNY-64 S-box with `MSKsbox` attached, d=2 and d=3.
- Starvation:
  - Stimulus: `rnd_valid`=0 in P3.
  - Required: ERR on the next cycle, `err`=1, no `out_valid`, `en4`/`en5` never asserted.
  - Required: next accept possible 2 cycles after P3.
- `err_clr`:
  - Stimulus: pulse with no starvation → `err`=0.
  - Stimulus: pulse in the same cycle as a new starvation → `err` stays 1.
- Asynchronous reset:
  - Stimulus: assert `rst_n` low mid-P4, between edges.
  - Required: enables and `ctrl` go to 0 immediately, no `out_valid`, `in_ready`=1 after release.
- `STARVE_ABORT`=0:
  - Stimulus: `rnd_valid`=0 all cycles.
  - Required: full 7-cycle schedule completes, `err`=0.
